// File: rtl/output_vc_status_tracker_pkg.sv
// Shared router types: output-VC ownership states and credit counter sizing.
// Types only; no timing or flow control.
package output_vc_status_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } vc_state_t;

    // A counter must be able to hold every value from 0 to depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/output_vc_status_tracker_if.sv
// Bundle of allocator events, credit returns and per-output-VC status masks.
// Latency is set by the consumer; there is no backpressure, events are single-cycle pulses.
interface output_vc_status_tracker_if
    import output_vc_status_tracker_pkg::*;
#(
    parameter int N            = 5,
    parameter int M            = 4,
    parameter int BUFFER_DEPTH = 8
);
    localparam int OW = $clog2(N);
    localparam int CW = credit_width(BUFFER_DEPTH);

    logic [N-1:0][M-1:0]         alloc_valid;
    logic [N-1:0][M-1:0][OW-1:0] alloc_owner;
    logic [N-1:0][M-1:0]         flit_sent;
    logic [N-1:0][M-1:0]         flit_sent_tail;
    logic [N-1:0][M-1:0]         credit_return;
    logic [N-1:0][M-1:0]         vc_on_off;
    logic [N-1:0][M-1:0]         sw_on_off;
    logic [N-1:0][M-1:0][OW-1:0] vc_owner;
    logic [N-1:0][M-1:0][CW-1:0] credit_count;
    logic [N-1:0][M-1:0]         protocol_error;

    modport master (
        output alloc_valid, alloc_owner, flit_sent, flit_sent_tail, credit_return,
        input  vc_on_off, sw_on_off, vc_owner, credit_count, protocol_error
    );

    modport slave (
        input  alloc_valid, alloc_owner, flit_sent, flit_sent_tail, credit_return,
        output vc_on_off, sw_on_off, vc_owner, credit_count, protocol_error
    );

endinterface

// File: rtl/output_vc_status_tracker_entry.sv
// One output VC: ownership FSM, downstream credit counter, owner and sticky error.
// Latency 1 cycle, outputs decoded from registers only; no backpressure, illegal events are flagged.
module output_vc_status_entry
    import output_vc_status_tracker_pkg::*;
#(
    parameter int N            = 5,
    parameter int BUFFER_DEPTH = 8,
    localparam int OW          = $clog2(N),
    localparam int CW          = credit_width(BUFFER_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_alloc_valid,
    input  logic [OW-1:0] i_alloc_owner,
    input  logic          i_flit_sent,
    input  logic          i_flit_sent_tail,
    input  logic          i_credit_return,
    output logic          o_vc_on_off,
    output logic          o_sw_on_off,
    output logic [OW-1:0] o_vc_owner,
    output logic [CW-1:0] o_credit_count,
    output logic          o_protocol_error
);
    localparam logic [CW-1:0] FULL = CW'(BUFFER_DEPTH);

    vc_state_t     r_state;
    logic [CW-1:0] r_count;
    logic [OW-1:0] r_owner;
    logic          r_error;

    logic [CW-1:0] w_count_next;
    logic          w_credit_err;
    logic          w_proto_err;

    // A send and a return in the same cycle cancel, so neither can saturate.
    always_comb begin
        w_count_next = r_count;
        w_credit_err = 1'b0;
        if (i_flit_sent && !i_credit_return) begin
            if (r_count == '0) w_credit_err = 1'b1;
            else               w_count_next = r_count - CW'(1);
        end else if (!i_flit_sent && i_credit_return) begin
            if (r_count == FULL) w_credit_err = 1'b1;
            else                 w_count_next = r_count + CW'(1);
        end
    end

    assign w_proto_err = (i_alloc_valid && (r_state != IDLE)) ||
                         (i_flit_sent   && (r_state != ACTIVE));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= FULL;
            r_owner <= '0;
            r_error <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_error <= r_error | w_credit_err | w_proto_err;
            case (r_state)
                IDLE: begin
                    if (i_alloc_valid) begin
                        r_state <= ACTIVE;
                        r_owner <= i_alloc_owner;
                    end
                end
                ACTIVE: begin
                    if (i_flit_sent && i_flit_sent_tail) r_state <= DRAIN;
                end
                DRAIN: begin
                    // Released only once the downstream buffer is completely empty.
                    if (w_count_next == FULL) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_vc_on_off      = (r_state != IDLE);
    assign o_sw_on_off      = (r_count == '0);
    assign o_vc_owner       = r_owner;
    assign o_credit_count   = r_count;
    assign o_protocol_error = r_error;

endmodule

// File: rtl/output_vc_status_tracker.sv
// Router-wide array of output-VC status entries feeding the VC and switch allocator masks.
// Latency 1 cycle; no backpressure, every event is absorbed in the cycle it arrives.
module output_vc_status_tracker
    import output_vc_status_tracker_pkg::*;
#(
    parameter int N            = 5,
    parameter int M            = 4,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    output_vc_status_tracker_if.slave  bus
);
    localparam int OW = $clog2(N);
    localparam int CW = credit_width(BUFFER_DEPTH);

    logic [N-1:0][M-1:0]         w_vc_on_off;
    logic [N-1:0][M-1:0]         w_sw_on_off;
    logic [N-1:0][M-1:0][OW-1:0] w_vc_owner;
    logic [N-1:0][M-1:0][CW-1:0] w_credit_count;
    logic [N-1:0][M-1:0]         w_protocol_error;

    for (genvar p = 0; p < N; p++) begin : g_port
        for (genvar v = 0; v < M; v++) begin : g_vc
            output_vc_status_entry #(
                .N            (N),
                .BUFFER_DEPTH (BUFFER_DEPTH)
            ) u_entry (
                .clk              (clk),
                .reset            (reset),
                .i_alloc_valid    (bus.alloc_valid[p][v]),
                .i_alloc_owner    (bus.alloc_owner[p][v]),
                .i_flit_sent      (bus.flit_sent[p][v]),
                .i_flit_sent_tail (bus.flit_sent_tail[p][v]),
                .i_credit_return  (bus.credit_return[p][v]),
                .o_vc_on_off      (w_vc_on_off[p][v]),
                .o_sw_on_off      (w_sw_on_off[p][v]),
                .o_vc_owner       (w_vc_owner[p][v]),
                .o_credit_count   (w_credit_count[p][v]),
                .o_protocol_error (w_protocol_error[p][v])
            );
        end
    end

    assign bus.vc_on_off      = w_vc_on_off;
    assign bus.sw_on_off      = w_sw_on_off;
    assign bus.vc_owner       = w_vc_owner;
    assign bus.credit_count   = w_credit_count;
    assign bus.protocol_error = w_protocol_error;

endmodule

// File: tb/tb_output_vc_status_tracker.sv
// Directed bench for the output-VC status tracker; expectations queued as stimulus is driven.
module tb_output_vc_status_tracker;
    localparam int N  = 5;
    localparam int M  = 4;
    localparam int D  = 8;
    localparam int OW = $clog2(N);
    localparam int CW = $clog2(D + 1);

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    output_vc_status_tracker_if #(.N(N), .M(M), .BUFFER_DEPTH(D)) vif ();

    output_vc_status_tracker #(.N(N), .M(M), .BUFFER_DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    p;
        int    v;
        int    vc;
        int    sw;
        int    cnt;
        int    own;
        int    err;
    } exp_t;

    exp_t exp_q[$];

    task automatic cmp(input string tag, input string fld, input int got, input int want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s.%s got %0d expected %0d", tag, fld, got, want);
        end
    endtask

    task automatic push(input string tag, input int p, input int v, input int vc, input int sw,
                        input int cnt, input int own, input int err);
        exp_t e;
        e.tag = tag; e.p = p; e.v = v; e.vc = vc; e.sw = sw;
        e.cnt = cnt; e.own = own; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic push_all_reset(input string tag);
        for (int p = 0; p < N; p++)
            for (int v = 0; v < M; v++)
                push(tag, p, v, 0, 0, D, 0, 0);
    endtask

    task automatic check_q();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.tag, "vc_on_off",      int'(vif.vc_on_off[e.p][e.v]),      e.vc);
            cmp(e.tag, "sw_on_off",      int'(vif.sw_on_off[e.p][e.v]),      e.sw);
            cmp(e.tag, "credit_count",   int'(vif.credit_count[e.p][e.v]),   e.cnt);
            cmp(e.tag, "vc_owner",       int'(vif.vc_owner[e.p][e.v]),       e.own);
            cmp(e.tag, "protocol_error", int'(vif.protocol_error[e.p][e.v]), e.err);
        end
    endtask

    task automatic clear_inputs();
        vif.alloc_valid    = '0;
        vif.alloc_owner    = '0;
        vif.flit_sent      = '0;
        vif.flit_sent_tail = '0;
        vif.credit_return  = '0;
    endtask

    // Inputs driven now are sampled at the next edge; results checked 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        #1;
        check_q();
        clear_inputs();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state after three idle cycles
        cycle();
        cycle();
        push_all_reset("reset_idle");
        cycle();

        // Allocate [2][1] to port 3 and send an 8-flit packet with no returns
        vif.alloc_valid[2][1] = 1'b1;
        vif.alloc_owner[2][1] = OW'(3);
        push("alloc21", 2, 1, 1, 0, 8, 3, 0);
        cycle();
        for (int i = 0; i < 8; i++) begin
            vif.flit_sent[2][1]      = 1'b1;
            vif.flit_sent_tail[2][1] = (i == 7);
            push("send21", 2, 1, 1, (i == 7) ? 1 : 0, 7 - i, 3, 0);
            cycle();
        end
        // Drain: blocked until the eighth credit is back
        for (int i = 0; i < 8; i++) begin
            vif.credit_return[2][1] = 1'b1;
            push("ret21", 2, 1, (i < 7) ? 1 : 0, 0, i + 1, 3, 0);
            cycle();
        end
        push("idle21_owner_kept", 2, 1, 0, 0, 8, 3, 0);
        cycle();

        // [1][0]: bring count to 4, then simultaneous send and return for 5 cycles
        vif.alloc_valid[1][0] = 1'b1;
        vif.alloc_owner[1][0] = OW'(2);
        push("alloc10", 1, 0, 1, 0, 8, 2, 0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            vif.flit_sent[1][0] = 1'b1;
            push("send10", 1, 0, 1, 0, 7 - i, 2, 0);
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            vif.flit_sent[1][0]     = 1'b1;
            vif.credit_return[1][0] = 1'b1;
            push("sendret10", 1, 0, 1, 0, 4, 2, 0);
            cycle();
        end
        // Re-allocation of an ACTIVE VC is ignored and flagged
        vif.alloc_valid[1][0] = 1'b1;
        vif.alloc_owner[1][0] = OW'(1);
        push("realloc10", 1, 0, 1, 0, 4, 2, 1);
        cycle();
        push("realloc10_sticky", 1, 0, 1, 0, 4, 2, 1);
        cycle();

        // Credit return at full saturates and flags
        vif.credit_return[0][3] = 1'b1;
        push("retfull03", 0, 3, 0, 0, 8, 0, 1);
        cycle();
        push("retfull03_sticky", 0, 3, 0, 0, 8, 0, 1);
        cycle();

        // Send on an IDLE VC still consumes a credit and flags
        vif.flit_sent[4][2] = 1'b1;
        push("send_idle42", 4, 2, 0, 0, 7, 0, 1);
        cycle();

        // [3][0]: send at zero credits saturates and flags
        vif.alloc_valid[3][0] = 1'b1;
        vif.alloc_owner[3][0] = OW'(1);
        push("alloc30", 3, 0, 1, 0, 8, 1, 0);
        cycle();
        for (int i = 0; i < 8; i++) begin
            vif.flit_sent[3][0] = 1'b1;
            push("send30", 3, 0, 1, (i == 7) ? 1 : 0, 7 - i, 1, 0);
            cycle();
        end
        vif.flit_sent[3][0] = 1'b1;
        push("send_empty30", 3, 0, 1, 1, 0, 1, 1);
        cycle();

        // [0][0]: tail at full count with a return -> DRAIN, IDLE next edge, then re-grant
        vif.alloc_valid[0][0] = 1'b1;
        vif.alloc_owner[0][0] = OW'(1);
        push("alloc00", 0, 0, 1, 0, 8, 1, 0);
        cycle();
        vif.flit_sent[0][0]      = 1'b1;
        vif.flit_sent_tail[0][0] = 1'b1;
        vif.credit_return[0][0]  = 1'b1;
        push("tail_full00", 0, 0, 1, 0, 8, 1, 0);
        cycle();
        push("drain_done00", 0, 0, 0, 0, 8, 1, 0);
        cycle();
        vif.alloc_valid[0][0] = 1'b1;
        vif.alloc_owner[0][0] = OW'(4);
        push("regrant00", 0, 0, 1, 0, 8, 4, 0);
        cycle();

        // [3][3] into DRAIN at count 3, then reset mid-packet
        vif.alloc_valid[3][3] = 1'b1;
        vif.alloc_owner[3][3] = OW'(4);
        push("alloc33", 3, 3, 1, 0, 8, 4, 0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            vif.flit_sent[3][3]      = 1'b1;
            vif.flit_sent_tail[3][3] = (i == 4);
            push("send33", 3, 3, 1, 0, 7 - i, 4, 0);
            if (i == 4) begin
                push("pre_rst10", 1, 0, 1, 0, 4, 2, 1);
                push("pre_rst21", 2, 1, 0, 0, 8, 3, 0);
                push("pre_rst30", 3, 0, 1, 1, 0, 1, 1);
            end
            cycle();
        end
        // Inputs active during reset must be ignored
        reset = 1'b0;
        vif.flit_sent[3][3]     = 1'b1;
        vif.alloc_valid[4][0]   = 1'b1;
        vif.alloc_owner[4][0]   = OW'(2);
        vif.credit_return[1][0] = 1'b1;
        push_all_reset("post_rst");
        cycle();
        reset = 1'b1;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/output_vc_status_tracker.md
# output_vc_status_tracker

Per-router tracker of every output virtual channel's ownership and downstream credit state. It sits beside the VC and switch allocators. It consumes VC-allocation grants, switch-traversal events and downstream credit returns, and produces the per-output-VC availability masks those allocators use as `on_off` inputs, where 1 means blocked. It enforces atomic VC reallocation: an output VC becomes free again only after its tail flit has left and the downstream buffer has fully drained.

## Interface
Parameters:
- `N`, default 5: number of router ports.
- `M`, default 4: number of virtual channels per port.
- `BUFFER_DEPTH`, default 8: downstream input-buffer depth per VC, in flits. This is also the initial credit count.

Ports:
- `clk`  in  1  router clock.
- `reset`  in  1  synchronous, active-low reset.
- `alloc_valid`  in  [N-1:0][M-1:0]  output VC [port][vc] was granted this cycle.
- `alloc_owner`  in  [N-1:0][M-1:0][$clog2(N)-1:0]  input port that won the VC; sampled with `alloc_valid`.
- `flit_sent`  in  [N-1:0][M-1:0]  one flit left on the output VC this cycle.
- `flit_sent_tail`  in  [N-1:0][M-1:0]  the sent flit is a tail; only meaningful with `flit_sent`.
- `credit_return`  in  [N-1:0][M-1:0]  downstream freed one slot of that VC.
- `vc_on_off`  out  [N-1:0][M-1:0]  1 when the VC is not IDLE; drives the VC allocator mask.
- `sw_on_off`  out  [N-1:0][M-1:0]  1 when the credit count is 0; drives the switch allocator mask.
- `vc_owner`  out  [N-1:0][M-1:0][$clog2(N)-1:0]  input port currently holding the VC.
- `credit_count`  out  [N-1:0][M-1:0][$clog2(BUFFER_DEPTH+1)-1:0]  current credits.
- `protocol_error`  out  [N-1:0][M-1:0]  sticky per-VC error flag.

## Operation
Each [port][vc] entry is independent and holds a 3-state FSM, a credit counter, an owner register and an error flag.

State machine:
- IDLE -> ACTIVE on `alloc_valid`. `vc_owner` <= `alloc_owner`.
- ACTIVE -> DRAIN on `flit_sent & flit_sent_tail`.
- DRAIN -> IDLE when the next credit count equals `BUFFER_DEPTH`.
- Every other case holds the current state.

Credit counter:
- count_next = count - `flit_sent` + `credit_return`.
- Send and return in the same cycle: count unchanged.
- Send at 0: count saturates at 0 and sets error.
- Return at `BUFFER_DEPTH`: count saturates at `BUFFER_DEPTH` and sets error.

Other errors (`protocol_error` is sticky and clears only on reset):
- `alloc_valid` while not IDLE: allocation ignored, state and owner unchanged, error set.
- `flit_sent` while IDLE or DRAIN: credit accounting still applied, state unchanged, error set.

Owner register:
- `vc_owner` holds its value until the next allocation; it is not cleared on return to IDLE.

Outputs:
- `vc_on_off` = (state != IDLE).
- `sw_on_off` = (count == 0).
- Both are decoded from registered state only, with no combinational path from inputs.

## Timing
- All state updates on the rising edge of `clk`.
- Inputs sampled in cycle t take effect in the registered outputs at t+1. Latency is 1 cycle and there is no input-to-output combinational path.
- Reset (`reset`=0 at an edge) forces every entry to:
  - state IDLE, count `BUFFER_DEPTH`, owner 0, error 0;
  - therefore `vc_on_off`=0, `sw_on_off`=0, `credit_count`=`BUFFER_DEPTH`, `vc_owner`=0, `protocol_error`=0.
- Reset asserted mid-packet discards all state. Reset has priority over every input.
- Single-flit packet: alloc at t, head+tail sent at t+k. The VC is in DRAIN at t+k+1 and reaches IDLE one cycle after the last credit returns.
- Tail sent in the same cycle the count is already full with a simultaneous return: the VC goes to DRAIN, then to IDLE on the following edge.
- Minimum VC turnaround, tail to re-grantable: 2 cycles, and only when credits are already back to full.

## Structure
- Shared router package: `vc_state_t` enum {IDLE, ACTIVE, DRAIN}, and credit width as a function of `BUFFER_DEPTH`.
- Sub-module `output_vc_status_entry`: one FSM, counter, owner and error flag. It is instantiated N×M in a generate loop. The top level is wiring and output packing only.

## Test plan
- Reset, then idle for 3 cycles -> all `credit_count`=8, `vc_on_off`=0, `sw_on_off`=0, `protocol_error`=0.
- Alloc [2][1] owner 3, send 8 flits back-to-back with the tail last and no returns -> `vc_on_off[2][1]`=1 from the cycle after alloc, `vc_owner`=3, count 8->0, `sw_on_off`=1 after the 8th send, state DRAIN.
- Continue the previous scenario: return 8 credits one per cycle -> VC stays blocked until the 8th return, then `vc_on_off`=0 the next cycle with count=8.
- Send and return on the same VC for 5 consecutive cycles at count 4 -> count stays 4, no error.
- Second `alloc_valid` on an ACTIVE VC with owner 1 -> owner unchanged, `protocol_error` set and sticky. Separately, a return at count 8 -> count stays 8 and error set.
- Assert `reset`=0 while a VC is in DRAIN with count 3 -> next cycle IDLE, count 8, error 0. All other VCs are unaffected before reset and cleared after it.
